pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock, rising-edge active.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have: idex_memR  in  1  ID/EX holds a load; idex_rt  in  5  its destination.
REQ-005 SHALL have: exmem_memR, exmem_memW  in  1 each  EX/MEM holds a load/store.
REQ-006 SHALL have: exmem_pcSel, exmem_zero  in  1 each  branch select and ALU zero in EX/MEM.
REQ-007 SHALL have: dmem_ack  in  1  data-memory completion.
REQ-008 SHALL have: dmem_req  out  1  data-memory request.
REQ-009 SHALL have: pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  stage load enables.
REQ-010 SHALL have: ifid_flush, idex_flush, exmem_flush  out  1 each  one-cycle stage clear requests.
REQ-011 SHALL have: bus_err  out  1  memory-timeout indication.
REQ-012 SHALL have: stall_cnt  out  16  saturating count of frozen cycles.

Function
REQ-013 SHALL implement FSM states RUN, WAIT, ERR.
REQ-014 In RUN with no hazard: all write enables = 1, all flushes = 0, dmem_req = 0.
REQ-015 mem_op = exmem_memR | exmem_memW; in RUN, dmem_req SHALL equal mem_op (combinational).
REQ-016 In RUN with mem_op and dmem_ack both high: the pipeline advances that cycle (REQ-014 enables) and the FSM stays in RUN.
REQ-017 In RUN with mem_op high and dmem_ack low: all write enables = 0; the FSM goes to WAIT; the wait counter loads 1.
REQ-018 In WAIT: dmem_req = 1 and all write enables = 0; the wait counter increments each cycle.
REQ-019 In WAIT with dmem_ack high: all write enables = 1 that cycle, and the FSM goes to RUN.
REQ-020 In WAIT with the wait counter equal to TIMEOUT (255) and dmem_ack low: the FSM goes to ERR.
REQ-021 In ERR: bus_err = 1, dmem_req = 0, and all enables and flushes = 0 until reset.
REQ-022 Branch taken = exmem_pcSel & exmem_zero, evaluated only in a cycle where the pipeline advances.
  - Effect: ifid_flush = idex_flush = exmem_flush = 1; pc_write = 1.
REQ-023 Load-use = idex_memR & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt), evaluated only in an advancing cycle.
  - Effect: pc_write = 0, ifid_write = 0, idex_flush = 1 (bubble).
  - Other stages advance.
REQ-024 Priority SHALL be: memory freeze, then branch, then load-use. A taken branch suppresses the load-use stall in the same cycle.
REQ-025 stall_cnt SHALL increment on every cycle where any write enable is 0 (including ERR), saturating at 0xFFFF.
REQ-026 dmem_req SHALL stay high from WAIT entry until the ack cycle, with no deassertion gap.

Reset
REQ-027 rst low SHALL immediately force the following values:
  - FSM to RUN; wait counter = 0; stall_cnt = 0; bus_err = 0.
  - Outputs follow RUN with EX/MEM inputs as presented.
REQ-028 Reset asserted in WAIT or ERR SHALL abandon the access: dmem_req drops while rst is low.
REQ-029 Release SHALL take effect at the first rising clk edge after rst rises.

Structure
REQ-030 Package pipe_hazard_pkg SHALL hold the state enumeration (2-bit), TIMEOUT = 8'd255, and the stall_cnt width constant.
REQ-031 Load-use comparison SHALL be a combinational sub-module named load_use_detect. The FSM, counters and priority logic stay in pipe_hazard_ctrl.

Verification
REQ-032 Stimulus: idex_memR = 1, idex_rt = 8, id_rs = 8 for one cycle.
  - Response: pc_write = 0, ifid_write = 0, idex_flush = 1, exmem_write = 1.
  - Next cycle with idex_memR = 0: all writes = 1.
REQ-033 Stimulus: idex_rt = 0, idex_memR = 1, id_rs = 0.
  - Response: no stall; all writes = 1.
REQ-034 Stimulus: exmem_memR = 1, dmem_ack low for 3 cycles then high.
  - Response: dmem_req high for 4 cycles; writes = 0 for 3 cycles, then 1 on the ack cycle; stall_cnt = 3.
REQ-035 Stimulus: exmem_pcSel = 1, exmem_zero = 1, and a load-use hazard in the same cycle.
  - Response: three flushes = 1, pc_write = 1, ifid_write = 1.
REQ-036 Stimulus: exmem_memW = 1, dmem_ack held low.
  - Response: ERR entered 256 cycles after the request; bus_err = 1 and enables = 0.
  - rst low then clears bus_err, stall_cnt = 0, RUN.
REQ-037 Stimulus: stall_cnt preloaded near saturation via a long ERR dwell.
  - Response: holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

  // Controller states: normal operation, waiting on data memory, bus error
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Register-file index width
  localparam int REG_W = 5;

  // Memory wait counter width and the wait value at which a missing ack is fatal
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] TIMEOUT = 8'd255;

  // Frozen-cycle counter width and its saturation value
  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Stage load enables, MSB first: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_en_t;

  // Stage clear requests, MSB first: IF/ID, ID/EX, EX/MEM
  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } stage_flush_t;

  // Increment that sticks at the all-ones value
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    logic [STALL_W-1:0] one;
    one = {{(STALL_W-1){1'b0}}, 1'b1};
    return (v == STALL_MAX) ? v : v + one;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the load in ID/EX writes a register that
// the instruction in ID reads. Register 0 is hardwired and never conflicts.
module load_use_detect
  import pipe_hazard_pkg::*;
(
  input  logic             idex_memR,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  logic [REG_W-1:0] src [2];
  logic [1:0]       src_match;

  assign src[0] = id_rs;
  assign src[1] = id_rt;

  // One comparator per source operand of the ID instruction
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = (src[gi] == idex_rt);
    end
  endgenerate

  assign hazard = idex_memR & (idex_rt != '0) & (|src_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freezes the pipe on slow data-memory accesses,
// flushes on taken branches, inserts a bubble on load-use, and counts
// frozen cycles. A missing memory ack for TIMEOUT wait cycles latches a
// bus error that only reset clears.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               idex_memR,
  input  logic [REG_W-1:0]   idex_rt,
  input  logic               exmem_memR,
  input  logic               exmem_memW,
  input  logic               exmem_pcSel,
  input  logic               exmem_zero,
  input  logic               dmem_ack,
  output logic               dmem_req,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               idex_write,
  output logic               exmem_write,
  output logic               memwb_write,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               bus_err,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next;

  logic                mem_op;
  logic                req_raw;
  logic                advance;
  logic                err_now;
  logic                load_use;
  logic                branch_taken;
  logic                lu_stall;
  stage_en_t           en;
  stage_flush_t        fl;

  load_use_detect u_load_use_detect (
    .idex_memR (idex_memR),
    .idex_rt   (idex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .hazard    (load_use)
  );

  assign mem_op = exmem_memR | exmem_memW;

  // Next-state logic: decide whether the pipe advances this cycle
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    req_raw       = 1'b0;
    advance       = 1'b0;
    err_now       = 1'b0;
    case (state_reg)
      ST_RUN: begin
        req_raw = mem_op;
        if (mem_op && !dmem_ack) begin
          // Memory not ready: freeze now and start counting wait cycles
          state_next    = ST_WAIT;
          wait_cnt_next = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        // Request held continuously until the ack cycle
        req_raw       = 1'b1;
        wait_cnt_next = wait_cnt_reg + {{(WAIT_W-1){1'b0}}, 1'b1};
        if (dmem_ack) begin
          advance    = 1'b1;
          state_next = ST_RUN;
        end else if (wait_cnt_reg == TIMEOUT) begin
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        // Dead until reset; everything held off
        err_now = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Hazard priority within an advancing cycle: branch beats load-use
  always_comb begin
    branch_taken = advance & exmem_pcSel & exmem_zero;
    lu_stall     = advance & load_use & ~branch_taken;

    en.pc    = advance & ~lu_stall;
    en.ifid  = advance & ~lu_stall;
    en.idex  = advance;
    en.exmem = advance;
    en.memwb = advance;

    fl.ifid  = branch_taken;
    fl.idex  = branch_taken | lu_stall;
    fl.exmem = branch_taken;

    // Any stage held counts as a frozen cycle
    stall_cnt_next = (&en) ? stall_cnt_reg : sat_inc(stall_cnt_reg);
  end

  // State, wait counter and frozen-cycle counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Any in-flight access is abandoned while reset is held
  assign dmem_req    = req_raw & rst;
  assign bus_err     = err_now;
  assign stall_cnt   = stall_cnt_reg;

  assign pc_write    = en.pc;
  assign ifid_write  = en.ifid;
  assign idex_write  = en.idex;
  assign exmem_write = en.exmem;
  assign memwb_write = en.memwb;

  assign ifid_flush  = fl.ifid;
  assign idex_flush  = fl.idex;
  assign exmem_flush = fl.exmem;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table for single-cycle
// RUN behaviour plus hand sequences for freeze, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_memR, exmem_memR, exmem_memW, exmem_pcSel, exmem_zero, dmem_ack;
  logic        dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic        ifid_flush, idex_flush, exmem_flush, bus_err;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .idex_memR   (idex_memR),
    .idex_rt     (idex_rt),
    .exmem_memR  (exmem_memR),
    .exmem_memW  (exmem_memW),
    .exmem_pcSel (exmem_pcSel),
    .exmem_zero  (exmem_zero),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_write  (idex_write),
    .exmem_write (exmem_write),
    .memwb_write (memwb_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .bus_err     (bus_err),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        idex_memR;
    logic [4:0]  idex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        exmem_memR;
    logic        exmem_memW;
    logic        exmem_pcSel;
    logic        exmem_zero;
    logic        dmem_ack;
    logic [4:0]  wr;
    logic [2:0]  fl;
    logic        req;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  wr;
    logic [2:0]  fl;
    logic        req;
    logic        err;
    logic [15:0] stall;
  } sb_t;

  vec_t        vq[$];
  sb_t         sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_stall = 16'd0;

  sb_t         mon_s;
  logic [4:0]  got_wr;
  logic [2:0]  got_fl;

  // Scoreboard consumer: compare each expected record mid-cycle
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_s  = sbq.pop_front();
      got_wr = {pc_write, ifid_write, idex_write, exmem_write, memwb_write};
      got_fl = {ifid_flush, idex_flush, exmem_flush};
      n_checks++;
      if (got_wr === mon_s.wr && got_fl === mon_s.fl && dmem_req === mon_s.req &&
          bus_err === mon_s.err && stall_cnt === mon_s.stall) begin
        n_pass++;
        $display("ok   %s: wr=%b fl=%b req=%b err=%b stall=%0d", mon_s.name,
                 got_wr, got_fl, dmem_req, bus_err, stall_cnt);
      end else begin
        $display("FAIL %s: got wr=%b fl=%b req=%b err=%b stall=%0d, want wr=%b fl=%b req=%b err=%b stall=%0d",
                 mon_s.name, got_wr, got_fl, dmem_req, bus_err, stall_cnt,
                 mon_s.wr, mon_s.fl, mon_s.req, mon_s.err, mon_s.stall);
      end
    end
  end

  task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("ok   %s: %0h", name, got);
    end else begin
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One clock cycle with inputs already driven; optionally queue an expectation
  task automatic cyc(input string name, input bit chk, input logic [4:0] wr,
                     input logic [2:0] fl, input logic req, input logic err);
    sb_t s;
    if (chk) begin
      s.name  = name;
      s.wr    = wr;
      s.fl    = fl;
      s.req   = req;
      s.err   = err;
      s.stall = model_stall;
      sbq.push_back(s);
    end
    if (wr != 5'b11111 && model_stall != 16'hFFFF) model_stall = model_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    idex_memR = 0; idex_rt = 0; id_rs = 0; id_rt = 0;
    exmem_memR = 0; exmem_memW = 0; exmem_pcSel = 0; exmem_zero = 0; dmem_ack = 0;
  endtask

  task automatic apply(input vec_t v);
    idex_memR = v.idex_memR; idex_rt = v.idex_rt; id_rs = v.id_rs; id_rt = v.id_rt;
    exmem_memR = v.exmem_memR; exmem_memW = v.exmem_memW;
    exmem_pcSel = v.exmem_pcSel; exmem_zero = v.exmem_zero; dmem_ack = v.dmem_ack;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();

    // Table: name, idex_memR, idex_rt, id_rs, id_rt, memR, memW, pcSel, zero, ack, wr, fl, req
    vq.push_back('{"idle",          1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0});
    vq.push_back('{"lu_rs",         1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0});
    vq.push_back('{"lu_cleared",    1'b0, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0});
    vq.push_back('{"lu_rt",         1'b1, 5'd5,  5'd3,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0});
    vq.push_back('{"lu_r0",         1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0});
    vq.push_back('{"lu_nomatch",    1'b1, 5'd8,  5'd7,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0});
    vq.push_back('{"lu_r31",        1'b1, 5'd31, 5'd31, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0});
    vq.push_back('{"branch",        1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b111, 1'b0});
    vq.push_back('{"branch_nz",     1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0});
    vq.push_back('{"branch_over_lu",1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b111, 1'b0});
    vq.push_back('{"load_ack",      1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000, 1'b1});
    vq.push_back('{"store_ack_lu",  1'b1, 5'd9,  5'd9,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00111, 3'b010, 1'b1});

    // Reset state, checked while rst is still low
    #3;
    chk1("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk1("rst_bus_err", 32'(bus_err), 32'd0);
    chk1("rst_writes", 32'({pc_write, ifid_write, idex_write, exmem_write, memwb_write}), 32'h1F);
    chk1("rst_dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vq[i]) begin
      apply(vq[i]);
      cyc(vq[i].name, 1'b1, vq[i].wr, vq[i].fl, vq[i].req, 1'b0);
    end

    // Slow load: three unacked cycles then ack
    clear_in();
    exmem_memR = 1;
    cyc("slow_ld_c0", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    cyc("slow_ld_c1", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    cyc("slow_ld_c2", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    dmem_ack = 1;
    cyc("slow_ld_ack", 1'b1, 5'b11111, 3'b000, 1'b1, 1'b0);
    clear_in();
    cyc("slow_ld_after", 1'b1, 5'b11111, 3'b000, 1'b0, 1'b0);

    // Branch held back during freeze, taken on the ack cycle
    exmem_memR = 1; exmem_pcSel = 1; exmem_zero = 1;
    cyc("frz_branch", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    dmem_ack = 1;
    cyc("ack_branch", 1'b1, 5'b11111, 3'b111, 1'b1, 1'b0);
    clear_in();

    // Reset during WAIT abandons the request
    exmem_memR = 1;
    cyc("wait_rst_c0", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    cyc("wait_rst_c1", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk1("wait_rst_req", 32'(dmem_req), 32'd0);
    chk1("wait_rst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_stall = 16'd0;
    clear_in();
    cyc("wait_rst_run", 1'b1, 5'b11111, 3'b000, 1'b0, 1'b0);

    // Store never acked: ERR 256 cycles after the request
    exmem_memW = 1;
    cyc("to_req", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    for (int k = 1; k <= 255; k++) begin
      cyc($sformatf("to_wait%0d", k), (k == 1 || k >= 253), 5'b00000, 3'b000, 1'b1, 1'b0);
    end
    cyc("to_err", 1'b1, 5'b00000, 3'b000, 1'b0, 1'b1);
    dmem_ack = 1; exmem_pcSel = 1; exmem_zero = 1;
    cyc("err_sticky", 1'b1, 5'b00000, 3'b000, 1'b0, 1'b1);

    // Reset out of ERR
    rst = 1'b0;
    #1;
    chk1("err_rst_bus_err", 32'(bus_err), 32'd0);
    chk1("err_rst_stall", 32'(stall_cnt), 32'd0);
    chk1("err_rst_req", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_stall = 16'd0;
    clear_in();
    exmem_memW = 1; dmem_ack = 1;
    cyc("err_rst_run", 1'b1, 5'b11111, 3'b000, 1'b1, 1'b0);

    // Long ERR dwell to drive stall_cnt into saturation
    dmem_ack = 0;
    cyc("sat_req", 1'b1, 5'b00000, 3'b000, 1'b1, 1'b0);
    for (int k = 1; k <= 255; k++) cyc("sat_wait", 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0);
    while (model_stall < 16'hFFFD) cyc("sat_dwell", 1'b0, 5'b00000, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc($sformatf("sat_edge%0d", k), 1'b1, 5'b00000, 3'b000, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
